// File: rtl/minesweeper_ctrl.sv
// Minesweeper game controller: LFSR bomb placement, cursor, reveal/flag, win/lose and draw-engine handshake.
// Define MINESWEEPER_WRAP_EN to make cursor moves wrap around board edges instead of clamping.
module minesweeper_ctrl #(
   parameter int          COLS      = 8,
   parameter int          ROWS      = 8,
   parameter int          NUM_BOMBS = 10,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      confirm,
   input  logic                      flag,
   input  logic                      restart,
   input  logic                      key_valid,
   input  logic [3:0]                udlr,
   input  logic                      draw_done,
   output logic [1:0]                wl,
   output logic [COLS*ROWS-1:0]      bomb_grid,
   output logic [COLS*ROWS-1:0]      reveal_grid,
   output logic [COLS*ROWS-1:0]      flag_grid,
   output logic [$clog2(COLS)-1:0]   cursor_x,
   output logic [$clog2(ROWS)-1:0]   cursor_y,
   output logic                      d_enable,
   output logic                      d_cursor,
   output logic                      d_reveal,
   output logic [2:0]                cs
);

   localparam int N    = COLS * ROWS;
   localparam int XW   = $clog2(COLS);
   localparam int YW   = $clog2(ROWS);
   localparam int NW   = $clog2(N);
   localparam int CW   = $clog2(NUM_BOMBS + 1);
   localparam int SAFE = N - NUM_BOMBS;

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_SET_BOMB = 3'd1,
      S_GAME     = 3'd2,
      S_CHECK    = 3'd3,
      S_DRAW     = 3'd4,
      S_WIN      = 3'd5,
      S_LOSE     = 3'd6
   } state_t;

   state_t          state;
   logic [15:0]     lfsr;
   logic [CW-1:0]   placed;

   logic [XW-1:0]   cand_x;
   logic [YW-1:0]   cand_y;
   logic [NW-1:0]   cand_idx;
   logic [NW-1:0]   cur_idx;
   logic [XW-1:0]   nx;
   logic [YW-1:0]   ny;
   logic            cand_ok;
   logic            placed_last;
   logic            moved;
   logic            all_safe;
   logic            do_clear;

   assign cs = state;

   function automatic int popcount(input logic [N-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < N; i++) c = c + int'(v[i]);
      return c;
   endfunction

   always_ff @(posedge clock) begin
      if (!reset) lfsr <= LFSR_SEED;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign cand_x      = lfsr[XW-1:0];
   assign cand_y      = lfsr[XW+YW-1:XW];
   assign cand_idx    = NW'(cand_y) * NW'(COLS) + NW'(cand_x);
   assign cur_idx     = NW'(cursor_y) * NW'(COLS) + NW'(cursor_x);
   assign cand_ok     = (int'(cand_x) < COLS) && (int'(cand_y) < ROWS) && !bomb_grid[cand_idx];
   assign placed_last = (int'(placed) == NUM_BOMBS - 1);
   assign all_safe    = (popcount(reveal_grid) == SAFE);
   assign do_clear    = (state == S_INIT) || restart;

   // Target cursor for the current udlr; non-one-hot codes leave it unchanged so no move happens.
   always_comb begin
      nx = cursor_x;
      ny = cursor_y;
      case (udlr)
         4'b1000: begin
            if (cursor_y != '0) ny = cursor_y - YW'(1);
`ifdef MINESWEEPER_WRAP_EN
            else ny = YW'(ROWS - 1);
`endif
         end
         4'b0100: begin
            if (cursor_y != YW'(ROWS - 1)) ny = cursor_y + YW'(1);
`ifdef MINESWEEPER_WRAP_EN
            else ny = '0;
`endif
         end
         4'b0010: begin
            if (cursor_x != '0) nx = cursor_x - XW'(1);
`ifdef MINESWEEPER_WRAP_EN
            else nx = XW'(COLS - 1);
`endif
         end
         4'b0001: begin
            if (cursor_x != XW'(COLS - 1)) nx = cursor_x + XW'(1);
`ifdef MINESWEEPER_WRAP_EN
            else nx = '0;
`endif
         end
         default: ;
      endcase
   end

   assign moved = (nx != cursor_x) || (ny != cursor_y);

   // Draw handshake: d_enable is a one-cycle request qualified by d_cursor/d_reveal;
   // the controller then holds in S_DRAW until draw_done, accepting only restart meanwhile.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= S_INIT;
         wl          <= '0;
         bomb_grid   <= '0;
         reveal_grid <= '0;
         flag_grid   <= '0;
         cursor_x    <= '0;
         cursor_y    <= '0;
         placed      <= '0;
         d_enable    <= 1'b0;
         d_cursor    <= 1'b0;
         d_reveal    <= 1'b0;
      end else begin
         d_enable <= 1'b0;
         d_cursor <= 1'b0;
         d_reveal <= 1'b0;
         if (do_clear) begin
            wl          <= '0;
            bomb_grid   <= '0;
            reveal_grid <= '0;
            flag_grid   <= '0;
            cursor_x    <= '0;
            cursor_y    <= '0;
            placed      <= '0;
            state       <= (state == S_INIT) ? S_SET_BOMB : S_INIT;
         end else begin
            case (state)
               S_SET_BOMB: begin
                  if (cand_ok) begin
                     bomb_grid[cand_idx] <= 1'b1;
                     placed              <= placed + CW'(1);
                     if (placed_last) state <= S_GAME;
                  end
               end
               S_GAME: begin
                  if (confirm) begin
                     if (!flag_grid[cur_idx] && !reveal_grid[cur_idx]) begin
                        reveal_grid[cur_idx] <= 1'b1;
                        state                <= S_CHECK;
                     end
                  end else if (flag) begin
                     if (!reveal_grid[cur_idx]) begin
                        flag_grid[cur_idx] <= ~flag_grid[cur_idx];
                        d_enable           <= 1'b1;
                        d_reveal           <= 1'b1;
                        state              <= S_DRAW;
                     end
                  end else if (key_valid && moved) begin
                     cursor_x <= nx;
                     cursor_y <= ny;
                     d_enable <= 1'b1;
                     d_cursor <= 1'b1;
                     state    <= S_DRAW;
                  end
               end
               S_CHECK: begin
                  if (bomb_grid[cur_idx]) wl <= 2'b10;
                  else if (all_safe)      wl <= 2'b01;
                  d_enable <= 1'b1;
                  d_reveal <= 1'b1;
                  state    <= S_DRAW;
               end
               S_DRAW: begin
                  if (draw_done) begin
                     case (wl)
                        2'b01:   state <= S_WIN;
                        2'b10:   state <= S_LOSE;
                        default: state <= S_GAME;
                     endcase
                  end
               end
               S_WIN, S_LOSE: ;
               default: state <= S_INIT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_minesweeper_ctrl.sv
// Bench for minesweeper_ctrl on a 4x4 board with 3 bombs: draw requests are checked against an expected queue.
module tb_minesweeper_ctrl;

   localparam logic [3:0] UP    = 4'b1000;
   localparam logic [3:0] DOWN  = 4'b0100;
   localparam logic [3:0] LEFT  = 4'b0010;
   localparam logic [3:0] RIGHT = 4'b0001;

   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_GAME = 3'd2;
   localparam logic [2:0] S_DRAW = 3'd4;
   localparam logic [2:0] S_WIN  = 3'd5;
   localparam logic [2:0] S_LOSE = 3'd6;

`ifdef MINESWEEPER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        confirm;
   logic        flag;
   logic        restart;
   logic        key_valid;
   logic [3:0]  udlr;
   logic        draw_done;
   logic [1:0]  wl;
   logic [15:0] bomb_grid;
   logic [15:0] reveal_grid;
   logic [15:0] flag_grid;
   logic [1:0]  cursor_x;
   logic [1:0]  cursor_y;
   logic        d_enable;
   logic        d_cursor;
   logic        d_reveal;
   logic [2:0]  cs;

   // expected draw word: {d_cursor, d_reveal, wl, cursor_x, cursor_y}
   logic [7:0]  exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          mx = 0;
   int          my = 0;
   logic        prev_en = 1'b0;

   minesweeper_ctrl #(.COLS(4), .ROWS(4), .NUM_BOMBS(3), .LFSR_SEED(16'hACE1)) dut (
      .clock(clock), .reset(reset), .confirm(confirm), .flag(flag), .restart(restart),
      .key_valid(key_valid), .udlr(udlr), .draw_done(draw_done), .wl(wl),
      .bomb_grid(bomb_grid), .reveal_grid(reveal_grid), .flag_grid(flag_grid),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .d_enable(d_enable),
      .d_cursor(d_cursor), .d_reveal(d_reveal), .cs(cs)
   );

   // clock / reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // monitor: every draw request pops one expected word
   always @(negedge clock) begin
      if (reset) begin
         if ((d_cursor || d_reveal) && !d_enable) begin
            checks++;
            errors++;
            $display("FAIL qualifier_without_enable: got d_cursor=%0b d_reveal=%0b with d_enable=0", d_cursor, d_reveal);
         end
         if (d_enable) begin
            checks++;
            if (prev_en) begin
               errors++;
               $display("FAIL enable_width: d_enable high for two cycles");
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_draw: got %h with nothing expected", {d_cursor, d_reveal, wl, cursor_x, cursor_y});
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if ({d_cursor, d_reveal, wl, cursor_x, cursor_y} !== e) begin
                  errors++;
                  $display("FAIL draw_update: got %h expected %h", {d_cursor, d_reveal, wl, cursor_x, cursor_y}, e);
               end
            end
         end
         prev_en = d_enable;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_cmd(input logic c, input logic f, input logic r, input logic d);
      confirm = c; flag = f; restart = r; draw_done = d;
      tick();
      confirm = 1'b0; flag = 1'b0; restart = 1'b0; draw_done = 1'b0;
   endtask

   task automatic pulse_key(input logic [3:0] dir);
      key_valid = 1'b1; udlr = dir;
      tick();
      key_valid = 1'b0; udlr = 4'b0000;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      for (int i = 0; i < budget && cs != s; i++) tick();
      check(name, cs, s);
   endtask

   task automatic finish_draw(input logic [2:0] next, input bit extra_key);
      wait_state(S_DRAW, 8, "enter_draw");
      if (extra_key) pulse_key(DOWN);
      repeat (5) tick();
      pulse_cmd(1'b0, 1'b0, 1'b0, 1'b1);
      check("state_after_draw", cs, next);
   endtask

   // driver: one cursor move, with the expected result computed from the model cursor
   task automatic do_move(input logic [3:0] dir, input bit extra_key);
      int nx, ny;
      nx = mx; ny = my;
      case (dir)
         UP:      ny = (my > 0) ? my - 1 : (WRAP ? 3 : my);
         DOWN:    ny = (my < 3) ? my + 1 : (WRAP ? 0 : my);
         LEFT:    nx = (mx > 0) ? mx - 1 : (WRAP ? 3 : mx);
         default: nx = (mx < 3) ? mx + 1 : (WRAP ? 0 : mx);
      endcase
      if (nx != mx || ny != my) begin
         exp_q.push_back({2'b10, 2'b00, 2'(nx), 2'(ny)});
         pulse_key(dir);
         mx = nx; my = ny;
         finish_draw(S_GAME, extra_key);
      end else begin
         pulse_key(dir);
         repeat (3) tick();
         check("no_move_state", cs, S_GAME);
      end
      check("cursor_after_move", {cursor_x, cursor_y}, {2'(mx), 2'(my)});
   endtask

   task automatic goto(input int tx, input int ty);
      while (mx < tx) do_move(RIGHT, 1'b0);
      while (mx > tx) do_move(LEFT, 1'b0);
      while (my < ty) do_move(DOWN, 1'b0);
      while (my > ty) do_move(UP, 1'b0);
   endtask

   task automatic check_cleared(input string name);
      check({name, "_state"}, cs, S_INIT);
      check({name, "_grids"}, {bomb_grid, reveal_grid, flag_grid}, 48'd0);
      check({name, "_cursor"}, {cursor_x, cursor_y}, 4'd0);
      check({name, "_wl"}, wl, 2'b00);
   endtask

   initial begin
      int safe_q[$];
      int bomb_idx;
      int n;
      reset = 1'b0; confirm = 1'b0; flag = 1'b0; restart = 1'b0;
      key_valid = 1'b0; udlr = 4'b0000; draw_done = 1'b0;
      repeat (3) tick();
      check_cleared("reset");
      check("reset_d_enable", {d_enable, d_cursor, d_reveal}, 3'b000);

      reset = 1'b1;
      wait_state(S_GAME, 200, "init_to_game");
      check("bomb_count", $countones(bomb_grid), 3);
      check("game_wl", wl, 2'b00);

      // left at the edge, then back to column 0, then right with a stray key during the draw
      do_move(LEFT, 1'b0);
      goto(0, 0);
      do_move(RIGHT, 1'b1);

      for (int i = 0; i < 16; i++) if (!bomb_grid[i]) safe_q.push_back(i);
      check("safe_count", safe_q.size(), 13);

      // flag, blocked confirm, unflag
      goto(safe_q[0] % 4, safe_q[0] / 4);
      exp_q.push_back({2'b01, 2'b00, 2'(mx), 2'(my)});
      pulse_cmd(1'b0, 1'b1, 1'b0, 1'b0);
      finish_draw(S_GAME, 1'b0);
      check("flag_set", flag_grid, 16'(1) << safe_q[0]);
      pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      check("confirm_on_flag_state", cs, S_GAME);
      check("confirm_on_flag_reveal", reveal_grid, 16'd0);
      exp_q.push_back({2'b01, 2'b00, 2'(mx), 2'(my)});
      pulse_cmd(1'b0, 1'b1, 1'b0, 1'b0);
      finish_draw(S_GAME, 1'b0);
      check("flag_cleared", flag_grid, 16'd0);

      // reveal every safe cell: win on the thirteenth
      n = 0;
      foreach (safe_q[k]) begin
         goto(safe_q[k] % 4, safe_q[k] / 4);
         n++;
         exp_q.push_back({2'b01, (n == 13) ? 2'b01 : 2'b00, 2'(mx), 2'(my)});
         pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
         finish_draw((n == 13) ? S_WIN : S_GAME, 1'b0);
         if (k == 0) begin
            pulse_cmd(1'b0, 1'b1, 1'b0, 1'b0);
            repeat (3) tick();
            check("flag_on_revealed", {cs, flag_grid}, {S_GAME, 16'd0});
         end
      end
      check("win_wl", wl, 2'b01);
      check("win_reveal_count", $countones(reveal_grid), 13);
      pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) tick();
      check("win_holds", {cs, wl}, {S_WIN, 2'b01});

      pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0);
      check_cleared("restart_win");
      mx = 0; my = 0;
      wait_state(S_GAME, 200, "regame_lose");
      check("lose_bomb_count", $countones(bomb_grid), 3);

      // step on a bomb
      bomb_idx = 0;
      for (int i = 15; i >= 0; i--) if (bomb_grid[i]) bomb_idx = i;
      goto(bomb_idx % 4, bomb_idx / 4);
      exp_q.push_back({2'b01, 2'b10, 2'(mx), 2'(my)});
      pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
      finish_draw(S_LOSE, 1'b0);
      check("lose_wl", wl, 2'b10);

      // restart in the middle of a draw
      pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0);
      mx = 0; my = 0;
      wait_state(S_GAME, 200, "regame_draw");
      exp_q.push_back({2'b10, 2'b00, 2'd1, 2'd0});
      pulse_key(RIGHT);
      wait_state(S_DRAW, 8, "draw_before_restart");
      pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0);
      check_cleared("restart_draw");
      wait_state(S_GAME, 200, "regame_final");
      check("final_bomb_count", $countones(bomb_grid), 3);

      repeat (5) tick();
      check("pending_draws", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
